// File: rtl/sample_player.sv
// Sample playback engine: a DATA_W x 2^ADDR_W sample RAM loaded while idle and
// streamed out at a programmable rate, either looping or as a single shot.
module sample_player #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 12,
  parameter int DIV_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] loop_len,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              wrap,
  output logic              done,
  output logic              wr_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [ADDR_W-1:0]  r_cfg_len;
  logic [DIV_W-1:0]   r_cfg_div;
  logic               r_cfg_mode;
  logic               r_busy;
  logic [DATA_W-1:0]  r_sample;
  logic               r_valid;
  logic               r_wrap;
  logic               r_done;
  logic               r_wr_err;
  logic [DATA_W-1:0]  r_mem [2**ADDR_W];

  logic               w_mem_we;
  logic               w_last;

  // Writes are only accepted while idle; reset wins over a coincident write.
  assign w_mem_we = (r_state == S_IDLE) && wr_en && !sys_rst;
  assign w_last   = (r_rd_addr == r_cfg_len);

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (w_mem_we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Playback FSM; the registered read data doubles as the sample_out register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_div_cnt  <= '0;
      r_cfg_len  <= '0;
      r_cfg_div  <= '0;
      r_cfg_mode <= 1'b0;
      r_busy     <= 1'b0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= wr_en && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_cfg_len  <= loop_len;
            r_cfg_div  <= rate_div;
            r_cfg_mode <= mode;
            r_rd_addr  <= '0;
            r_div_cnt  <= '0;
            r_state    <= S_PLAY;
            r_busy     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_PLAY: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_div_cnt == r_cfg_div) begin
              r_div_cnt <= '0;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (r_div_cnt == '0) begin
              r_sample <= r_mem[r_rd_addr];
              r_valid  <= 1'b1;
              if (w_last) begin
                if (r_cfg_mode) begin
                  // Last one-shot sample: its valid and done appear together in DRAIN.
                  r_state <= S_DRAIN;
                  r_done  <= 1'b1;
                end else begin
                  r_rd_addr <= '0;
                  r_wrap    <= 1'b1;
                end
              end else begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign wrap         = r_wrap;
  assign done         = r_done;
  assign wr_err       = r_wr_err;

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player: each task drives one scenario and checks the
// packed output word {busy, valid, wrap, done, wr_err, sample_out} per cycle.
module tb_sample_player;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 12;
  localparam int DIV_W  = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] loop_len;
  logic [DIV_W-1:0]  rate_div;
  logic              mode;
  logic              start;
  logic              stop;
  logic              busy;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              wrap;
  logic              done;
  logic              wr_err;

  logic [DATA_W+4:0] obs;
  logic [DATA_W+4:0] exp;
  logic [DATA_W-1:0] exp_s;
  logic              v;
  int                n_checks = 0;
  int                n_fail   = 0;

  assign obs = {busy, sample_valid, wrap, done, wr_err, sample_out};

  always #5 sys_clk = ~sys_clk;

  sample_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .loop_len(loop_len), .rate_div(rate_div), .mode(mode),
    .start(start), .stop(stop), .busy(busy), .sample_out(sample_out),
    .sample_valid(sample_valid), .wrap(wrap), .done(done), .wr_err(wr_err)
  );

  task automatic set_cfg(input int len, input int div, input logic md);
    loop_len = ADDR_W'(len);
    rate_div = DIV_W'(div);
    mode     = md;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; set_cfg(0, 0, 1'b0);
    repeat (2) @(negedge sys_clk);
    exp_s = '0;
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp %h", obs, '0);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_idle got %h exp %h", obs, '0);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 200; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i);
      @(negedge sys_clk);
    end
    wr_en = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_loop();
    set_cfg(199, 0, 1'b0);
    for (int n = 0; n <= 252; n++) begin
      if (n >= 1) begin
        v = (n >= 2 && n <= 251);
        if (v) exp_s = DATA_W'((n - 2) % 200);
        exp = {(n <= 251), v, (v && exp_s == 10'd199), 1'b0, 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL loop n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0); stop = (n == 251);
      @(negedge sys_clk);
    end
  endtask

  task automatic test_oneshot();
    set_cfg(3, 4, 1'b1);
    for (int n = 0; n <= 19; n++) begin
      if (n >= 1) begin
        v = (n == 2 || n == 7 || n == 12 || n == 17);
        if (v) exp_s = DATA_W'((n - 2) / 5);
        exp = {(n <= 17), v, 1'b0, (n == 17), 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL oneshot n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0); stop = 1'b0;
      @(negedge sys_clk);
    end
  endtask

  task automatic test_wr_err();
    set_cfg(7, 0, 1'b0);
    for (int n = 0; n <= 21; n++) begin
      if (n >= 1) begin
        v = (n >= 2 && n <= 20);
        if (v) exp_s = DATA_W'((n - 2) % 8);
        exp = {(n <= 20), v, (v && exp_s == 10'd7), 1'b0, (n == 4), exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL wr_err n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0); stop = (n == 20);
      wr_en = (n == 3); wr_addr = ADDR_W'(5); wr_data = 10'h3FF;
      @(negedge sys_clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_stop();
    set_cfg(199, 4, 1'b1);
    for (int n = 0; n <= 8; n++) begin
      if (n >= 1) begin
        v = (n == 2);
        if (v) exp_s = '0;
        exp = {(n <= 6), v, 1'b0, 1'b0, 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL stop n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0); stop = (n == 6);
      @(negedge sys_clk);
    end
  endtask

  task automatic test_len0();
    set_cfg(0, 1, 1'b0);
    for (int n = 0; n <= 7; n++) begin
      if (n >= 1) begin
        v = (n == 2 || n == 4 || n == 6);
        if (v) exp_s = '0;
        exp = {(n <= 6), v, v, 1'b0, 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL len0_loop n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0); stop = (n == 6);
      @(negedge sys_clk);
    end
    set_cfg(0, 0, 1'b1);
    for (int n = 0; n <= 3; n++) begin
      if (n >= 1) begin
        v = (n == 2);
        exp = {(n <= 2), v, 1'b0, v, 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL len0_oneshot n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0); stop = 1'b0;
      @(negedge sys_clk);
    end
  endtask

  task automatic test_mid_reset();
    set_cfg(7, 0, 1'b0);
    for (int n = 0; n <= 17; n++) begin
      if (n >= 1) begin
        v = (n >= 2 && n <= 5) || (n >= 9 && n <= 16);
        if (n == 6) exp_s = '0;
        if (v) exp_s = (n <= 5) ? DATA_W'(n - 2) : DATA_W'(n - 9);
        exp = {((n <= 5) || (n >= 8 && n <= 16)), v, (v && n == 16), 1'b0, 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL mid_reset n=%0d got %h exp %h", n, obs, exp);
        end
      end
      sys_rst = (n == 5); start = (n == 0 || n == 5 || n == 7); stop = (n == 16);
      @(negedge sys_clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n <= 2; n++) begin
      if (n >= 1) begin
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL start_stop_idle n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0); stop = (n == 0);
      @(negedge sys_clk);
    end
    set_cfg(3, 0, 1'b1);
    for (int n = 0; n <= 7; n++) begin
      if (n >= 1) begin
        v = (n >= 2 && n <= 5);
        if (v) exp_s = DATA_W'(n - 2);
        exp = {(n <= 5), v, 1'b0, (n == 5), 1'b0, exp_s};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL start_while_busy n=%0d got %h exp %h", n, obs, exp);
        end
      end
      start = (n == 0 || n == 3); stop = 1'b0;
      if (n == 3) set_cfg(1, 5, 1'b0);
      @(negedge sys_clk);
    end
  endtask

  initial begin
    test_reset();
    load_mem();
    test_loop();
    test_oneshot();
    test_wr_err();
    test_stop();
    test_len0();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
